// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output Ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_a, bit_b, bit_d, br_nx;

    // Single full-subtractor cell shared by every bit position.
    assign bit_a = a_sh_q[0];
    assign bit_b = b_sh_q[0];
    assign bit_d = bit_a ^ bit_b ^ br_q;
    assign br_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = {bit_d, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_nx;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    bout_d  = br_nx;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB differs from borrow out of it.
                    ovf_d   = br_q ^ br_nx;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing Diff = A - B, one bit per clock, LSB first, with a borrow flip-flop carried between bits.
- It is the inverse-operation companion to the team's combinational ripple-carry adder datapath, for area-constrained paths where one full-subtractor cell is reused.
- Start/busy/done handshake. Results are held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only when busy==0.
- A  input  WIDTH  minuend, captured on the accepting edge.
- B  input  WIDTH  subtrahend, captured on the accepting edge.
- Diff  output  WIDTH  registered difference (A - B) mod 2^WIDTH.
- Bout  output  1  registered final borrow; 1 iff A < B unsigned.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when Diff/Bout become valid.

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-low; clock port named clk, reset port named rst_n.
- Reset (rst_n==0 at an edge): state=IDLE; Diff=0, Bout=0, busy=0, done=0; internal shift registers, borrow and bit counter cleared. Reset mid-operation aborts the operation; no done is produced.
- FSM states are IDLE, SHIFT and DONE.
- IDLE or DONE, start==1 at edge k:
  - latch A and B into shift registers; borrow=0; count=0; state goes to SHIFT; busy=1 from edge k.
  - Diff and Bout keep their old values until completion.
- SHIFT, each edge:
  - a = A_sh[0], b = B_sh[0], d = a^b^br.
  - br_next = (~a&b) | (~(a^b)&br).
  - d shifts into the result register at the MSB, the register shifts right, and both operand registers shift right.
  - count increments.
- Completion: after exactly WIDTH shift edges (edges k+1..k+WIDTH), on edge k+WIDTH:
  - Diff = assembled result, Bout = br_next, state goes to DONE, busy=0, done=1.
- DONE lasts one cycle. At the next edge done returns to 0 and state goes to IDLE, unless start==1, in which case a new operation is accepted (back-to-back; done still drops).
- Latency: done is visible WIDTH cycles after the accepting edge. Throughput is one result per WIDTH+1 cycles for back-to-back starts.
- start while busy==1 is ignored; A and B are not re-sampled.
- start held high continuously gives repeated operations, each accepted in the DONE cycle.
- Counter width is $clog2(WIDTH)+1; no wrap-around within an operation.
- Diff and Bout remain stable from done until the next completion, or until reset.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- When defined: extra output port Ovf (1 bit, registered, reset 0), updated together with Diff.
  - Ovf = two's-complement signed overflow of A - B, i.e. (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]).
  - Computed from the MSB-cycle borrow-in XOR borrow-out.
- When undefined: no Ovf port and no related logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 two cycles with start=1 -> Diff=0, Bout=0, busy=0, done=0. Release, start A=8'h00 B=8'h0A -> done exactly 8 cycles after acceptance, Diff=8'hF6, Bout=1.
- Vectors, each awaiting done:
  - A=8'h71 B=8'hCE -> Diff=8'hA3, Bout=1 (Ovf=1).
  - A=8'h6C B=8'h23 -> Diff=8'h49, Bout=0 (Ovf=0).
  - A=8'h1C B=8'h4B -> Diff=8'hD1, Bout=1 (Ovf=0).
- Start ignored while busy: start A=8'h10 B=8'h01, pulse start with A=8'hFF B=8'hFF at cycle 3 -> result Diff=8'h0F, Bout=0; a single done pulse only.
- Back-to-back: start held high with A=8'h80 B=8'h01 -> done every 9 cycles, Diff=8'h7F, Bout=0 (Ovf=1); busy low only in DONE cycles.
- Reset mid-operation: assert rst_n=0 at shift cycle 4 -> no done; outputs 0. A new start A=8'hFF B=8'h00 -> Diff=8'hFF, Bout=0.
- Boundary: A=B=8'hAA -> Diff=8'h00, Bout=0. A=8'h00 B=8'hFF -> Diff=8'h01, Bout=1. Diff/Bout stay stable for 20 idle cycles after done.
